// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the data-memory responder
package cpu_pkg;

    localparam int WORD_W      = 32;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Misaligned or beyond the last stored word
    function automatic logic addr_err(input logic [WORD_W-1:0] a, input int depth);
        return (a[1:0] != 2'b00) || ({2'b00, a[WORD_W-1:2]} >= WORD_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with one synchronous write and one asynchronous read port
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     widx_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     ridx_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[ridx_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder with stall and ack handshake
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] w_data_i,
    output logic              stall_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] r_data_o,
    output logic              err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] r_data_q, r_data_d;

    logic              req;
    logic              cur_op;
    logic [WORD_W-1:0] cur_addr;
    logic              cur_err;
    logic              done_next;
    logic              we;
    logic [AW-1:0]     ridx;
    logic [AW-1:0]     widx;
    logic [WORD_W-1:0] rdata;

    // In IDLE the live request is the transaction; afterwards the latched copy is
    always_comb begin
        req      = MemRead_i | MemWrite_i;
        cur_addr = (state_q == IDLE) ? addr_i : addr_q;
        cur_op   = (state_q == IDLE) ? (MemWrite_i ? OP_WR : OP_RD) : op_q;
        cur_err  = addr_err(cur_addr, DEPTH);
        ridx     = cur_addr[AW+1:2];
        widx     = addr_q[AW+1:2];
    end

    // Next-state, wait-state counter and request latch
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_next = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    op_d    = MemWrite_i ? OP_WR : OP_RD;
                    addr_d  = addr_i;
                    wdata_d = w_data_i;
                    if (LATENCY == 1) begin
                        state_d   = DONE;
                        cnt_d     = '0;
                        done_next = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    done_next = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load data is captured on the edge entering DONE and held until the next load
    always_comb begin
        r_data_d = r_data_q;
        if (done_next && (cur_op == OP_RD)) begin
            r_data_d = cur_err ? '0 : rdata;
        end
    end

    // Handshake outputs and the store commit at the end of the ack cycle
    always_comb begin
        stall_o = ((state_q == IDLE) && req) || (state_q == BUSY);
        ack_o   = (state_q == DONE);
        err_o   = ack_o && cur_err;
        we      = ack_o && (op_q == OP_WR) && !cur_err && !rst_i;
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            r_data_q <= r_data_d;
        end
    end

    assign r_data_o = r_data_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (we),
        .widx_i  (widx),
        .wdata_i (wdata_q),
        .ridx_i  (ridx),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd4 = 1'b0, wr4 = 1'b0;
    logic [31:0] a4 = '0, d4 = '0;
    logic        stall4, ack4, err4;
    logic [31:0] r4;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] a1 = '0, d1 = '0;
    logic        stall1, ack1, err1;
    logic [31:0] r1;

    int          cur = 0;
    logic        o_stall, o_ack, o_err;
    logic [31:0] o_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          bad;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(32), .LATENCY(4)) u_dut4 (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (rd4),
        .MemWrite_i (wr4),
        .addr_i     (a4),
        .w_data_i   (d4),
        .stall_o    (stall4),
        .ack_o      (ack4),
        .r_data_o   (r4),
        .err_o      (err4)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (rd1),
        .MemWrite_i (wr1),
        .addr_i     (a1),
        .w_data_i   (d1),
        .stall_o    (stall1),
        .ack_o      (ack1),
        .r_data_o   (r1),
        .err_o      (err1)
    );

    assign o_stall = (cur == 1) ? stall1 : stall4;
    assign o_ack   = (cur == 1) ? ack1   : ack4;
    assign o_err   = (cur == 1) ? err1   : err4;
    assign o_rdata = (cur == 1) ? r1     : r4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (cur == 1) begin
            rd1 = rd; wr1 = wr; a1 = a; d1 = d;
        end else begin
            rd4 = rd; wr4 = wr; a4 = a; d4 = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue at cycle T, hold (or drop at T+1), expect stall T..T+lat-1 and ack at T+lat
    task automatic txn(input string tag, input int lat, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic drop,
                       input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
        int stalls;
        int acks;
        stalls = 0;
        acks   = 0;
        drive(rd, wr, a, d);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            if (o_stall) stalls++;
            if (o_ack) acks++;
            step();
            if (drop && c == 0) drive(1'b0, 1'b0, a, d);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk($sformatf("%s_stall_cycles", tag), 32'(stalls), 32'(lat));
        chk($sformatf("%s_early_ack", tag), 32'(acks), 32'd0);
        chk($sformatf("%s_ack", tag), {31'b0, o_ack}, 32'd1);
        chk($sformatf("%s_no_stall_in_ack", tag), {31'b0, o_stall}, 32'd0);
        chk($sformatf("%s_err", tag), {31'b0, o_err}, {31'b0, exp_err});
        if (chk_rd) chk($sformatf("%s_rdata", tag), o_rdata, exp_rd);
        step();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall4 || ack4 || err4 || (r4 != 32'h0)) bad++;
            if (stall1 || ack1 || err1 || (r1 != 32'h0)) bad++;
            step();
        end
        chk("idle_after_reset", 32'(bad), 32'd0);

        cur = 0;
        txn("wr08",      4, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
        txn("rd08",      4, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        txn("wr04",      4, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0);
        txn("rd04_drop", 4, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678);
        txn("wr06_mis",  4, 1'b0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
        txn("rd04_keep", 4, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1234_5678);
        txn("rd80_oor",  4, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0);
        txn("rd08_again",4, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        txn("both0c",    4, 1'b1, 1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        txn("rd0c",      4, 1'b1, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5);
        txn("wr10_old",  4, 1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 32'h0);
        txn("rd10_old",  4, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1111_2222);

        drive(1'b0, 1'b1, 32'h0000_0010, 32'h3333_4444);
        step();
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdata_cleared", r4, 32'h0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (stall4 || ack4 || err4) bad++;
            step();
        end
        chk("rst_mid_quiet", 32'(bad), 32'd0);
        txn("rd10_after_rst", 4, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_2222);

        cur = 1;
        txn("l1_wr08", 1, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
        txn("l1_rd08", 1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        txn("l1_rd80", 1, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
